// File: rtl/pong_pkg.sv
// Shared definitions between the switch front end and the light-pong game core:
// LED count, index width and the lowest-set-bit encoder used to pick a strike.
package pong_pkg;

  localparam int NUM_LEDS  = 16;
  localparam int LED_IDX_W = 4;

  typedef struct packed {
    logic [NUM_LEDS-1:0]  onehot;
    logic [LED_IDX_W-1:0] idx;
  } strike_t;

  // Scans from the top down so the lowest set bit is the last one written.
  function automatic strike_t lowest_set_bit(input logic [NUM_LEDS-1:0] vec);
    strike_t r;
    r = '0;
    for (int i = NUM_LEDS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.onehot    = '0;
        r.onehot[i] = 1'b1;
        r.idx       = LED_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: two-flop synchronizer followed by a tick-driven debounce counter
// that flips the clean level after STABLE_TICKS consecutive disagreeing ticks.
module switch_debounce #(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic sw_i,
  output logic level_o
);

  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // sync stage 1 -> sync stage 2 -> debounced level
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pong_input_frontend.sv
// Player switch front end: debounces 16 slide switches into the player level vector
// and turns debounced rising edges into one-hot strike events over valid/ready.
module pong_input_frontend
  import pong_pkg::*;
#(
  parameter int TICK_DIV      = 100000,
  parameter int STABLE_TICKS  = 10,
  parameter int HOLDOFF_TICKS = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LEDS-1:0]  sw,
  output logic [NUM_LEDS-1:0]  player,
  output logic [NUM_LEDS-1:0]  strike,
  output logic [LED_IDX_W-1:0] strike_idx,
  output logic                 strike_valid,
  input  logic                 strike_ready,
  output logic                 drop,
  output logic                 multi
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ARM_W  = $clog2(STABLE_TICKS + 2);
  localparam int HOLD_W = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [ARM_W-1:0]  ARM_LAST   = ARM_W'(STABLE_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLDOFF_TICKS);

  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [ARM_W-1:0]     arm_cnt_q, arm_cnt_d;
  logic                 armed_q, armed_d;
  logic [NUM_LEDS-1:0]  player_q;
  logic [NUM_LEDS-1:0]  strike_q, strike_d;
  logic [LED_IDX_W-1:0] idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 drop_q, drop_d;
  logic                 multi_q, multi_d;

  logic                 tick;
  logic [NUM_LEDS-1:0]  rise;
  strike_t              lsb;
  logic                 accept;
  logic                 can_capture;

  assign tick = (tick_cnt_q == TICK_LAST);

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_bit
    switch_debounce #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_debounce (
      .clk_i   (clk),
      .reset_i (reset),
      .tick_i  (tick),
      .sw_i    (sw[g]),
      .level_o (player[g])
    );
  end

  always_comb begin
    rise        = player & ~player_q;
    lsb         = lowest_set_bit(rise);
    accept      = valid_q & strike_ready;
    can_capture = armed_q & ~valid_q & (hold_q == '0);

    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    // Arming waits STABLE_TICKS+1 ticks so switches already up at power-up settle silently.
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    if (tick && !armed_q) begin
      if (arm_cnt_q == ARM_LAST) armed_d = 1'b1;
      else                       arm_cnt_d = arm_cnt_q + ARM_W'(1);
    end

    hold_d = hold_q;
    if (accept)                      hold_d = HOLD_RELOAD;
    else if (tick && hold_q != '0)   hold_d = hold_q - HOLD_W'(1);

    valid_d  = valid_q;
    strike_d = strike_q;
    idx_d    = idx_q;
    if (accept) begin
      valid_d  = 1'b0;
      strike_d = '0;
      idx_d    = '0;
    end

    // can_capture excludes valid_q, so a rise in the acceptance cycle lands in drop.
    drop_d = 1'b0;
    if (rise != '0) begin
      if (can_capture) begin
        valid_d  = 1'b1;
        strike_d = lsb.onehot;
        idx_d    = lsb.idx;
      end else begin
        drop_d = 1'b1;
      end
    end

    multi_d = (rise & (rise - NUM_LEDS'(1))) != '0;
  end

  // edge-detect / capture / handshake stage
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
      player_q   <= '0;
      strike_q   <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      hold_q     <= '0;
      drop_q     <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      arm_cnt_q  <= arm_cnt_d;
      armed_q    <= armed_d;
      player_q   <= player;
      strike_q   <= strike_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      hold_q     <= hold_d;
      drop_q     <= drop_d;
      multi_q    <= multi_d;
    end
  end

  assign strike       = strike_q;
  assign strike_idx   = idx_q;
  assign strike_valid = valid_q;
  assign drop         = drop_q;
  assign multi        = multi_q;

endmodule

// File: tb/tb_pong_input_frontend.sv
// Directed scenarios plus randomized switch traffic, checked every cycle against a
// behavioural model of the switch front end.
module tb_pong_input_frontend;
  import pong_pkg::*;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int HT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = 16'h0001;
  logic        strike_ready = 1'b1;
  logic [15:0] player, strike;
  logic [3:0]  strike_idx;
  logic        strike_valid, drop, multi;

  always #5 clk = ~clk;

  pong_input_frontend #(
    .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLDOFF_TICKS(HT)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .player(player), .strike(strike),
    .strike_idx(strike_idx), .strike_valid(strike_valid), .strike_ready(strike_ready),
    .drop(drop), .multi(multi)
  );

  int n_cmp = 0;
  int n_err = 0;
  int dcnt = 0, mcnt = 0, vcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer tick counts, integer debounce run-lengths, a pending index.
  logic [15:0] m_s1 = '0, m_s2 = '0, m_player = '0, m_prev = '0;
  int          m_run[16];
  int          m_phase = 0, m_ticks = 0, m_hold = 0, m_idx = 0;
  bit          m_valid = 0, m_drop = 0, m_multi = 0, chk_en = 0;
  logic [15:0] t_rise, t_newp;
  bit          t_tick, t_armed, t_accept;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_player = '0; m_prev = '0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
      m_phase = 0; m_ticks = 0; m_hold = 0; m_idx = 0;
      m_valid = 0; m_drop = 0; m_multi = 0;
      chk_en = 1;
    end else begin
      t_tick   = (m_phase == TD - 1);
      t_armed  = (m_ticks >= ST + 1);
      t_rise   = m_player & ~m_prev;
      t_accept = m_valid && strike_ready;
      m_multi  = ($countones(t_rise) > 1);
      m_drop   = 0;
      if (t_accept) begin m_valid = 0; m_idx = 0; end
      if (t_rise != 0) begin
        if (t_armed && !t_accept && !m_valid && m_hold == 0) begin
          for (int i = 0; i < 16; i++) if (t_rise[i]) begin m_idx = i; break; end
          m_valid = 1;
        end else begin
          m_drop = 1;
        end
      end
      if (t_accept) m_hold = HT;
      else if (t_tick && m_hold > 0) m_hold--;
      t_newp = m_player;
      for (int i = 0; i < 16; i++) begin
        if (m_s2[i] == m_player[i]) m_run[i] = 0;
        else if (t_tick) begin
          m_run[i]++;
          if (m_run[i] == ST) begin t_newp[i] = ~m_player[i]; m_run[i] = 0; end
        end
      end
      m_s2 = m_s1; m_s1 = sw;
      m_prev = m_player; m_player = t_newp;
      if (t_tick) m_ticks++;
      m_phase = t_tick ? 0 : m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("player", player, m_player);
      chk("strike_valid", strike_valid, m_valid);
      chk("strike", strike, m_valid ? (32'd1 << m_idx) : 32'd0);
      chk("strike_idx", strike_idx, m_valid ? m_idx : 0);
      chk("drop", drop, m_drop);
      chk("multi", multi, m_multi);
      if (drop) dcnt++;
      if (multi) mcnt++;
      if (strike_valid) vcnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_cnt();
    dcnt = 0; mcnt = 0; vcnt = 0;
  endtask

  // Returns at the negedge where strike_valid is first seen; lat = cycles until player[b] rose.
  task automatic wait_strike(input int b, output int lat, output bit ok);
    lat = -1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lat < 0 && player[b]) lat = i;
      if (strike_valid) begin ok = 1; break; end
    end
  endtask

  task automatic chk_lat(input string name, input int lat);
    n_cmp++;
    if (lat < 9 || lat > 14) begin
      n_err++;
      $display("FAIL %s: latency %0d cycles, required 9..14", name, lat);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit ok;
    // Power-up with bit 0 already on: settles before arming, one drop, no strike.
    step(3);
    reset = 1'b0;
    clr_cnt();
    step(14);
    chk("pwrup_player", player, 16'h0001);
    step(16);
    chk("pwrup_no_strike", vcnt, 0);
    chk("pwrup_drop", dcnt, 1);

    // Single step on bit 8 with ready held high.
    sw = 16'h0000; step(20);
    sw = 16'h0100;
    wait_strike(8, lat, ok);
    chk("step_seen", ok, 1);
    chk_lat("step_latency", lat);
    chk("step_strike", strike, 16'h0100);
    chk("step_idx", strike_idx, 8);
    @(negedge clk);
    chk("step_one_cycle", strike_valid, 0);
    @(posedge clk); #1;

    // Bounce on bit 3.
    sw = 16'h0000; step(20);
    clr_cnt();
    for (int k = 0; k < 8; k++) begin sw[3] = ~sw[3]; step(5); end
    chk("bounce_player", player[3], 0);
    chk("bounce_no_strike", vcnt, 0);
    sw[3] = 1'b1;
    wait_strike(3, lat, ok);
    chk("bounce_seen", ok, 1);
    chk_lat("bounce_latency", lat);
    chk("bounce_idx", strike_idx, 3);
    @(posedge clk); #1;
    step(10);
    chk("bounce_single", vcnt, 1);

    // Two bits rising together.
    sw = 16'h0000; step(20);
    clr_cnt();
    sw = 16'h0024;
    wait_strike(2, lat, ok);
    chk("multi_seen", ok, 1);
    chk("multi_strike", strike, 16'h0004);
    chk("multi_idx", strike_idx, 2);
    @(posedge clk); #1;
    step(10);
    chk("multi_pulse", mcnt, 1);
    chk("multi_no_drop", dcnt, 0);

    // Backpressure, then holdoff after acceptance.
    sw = 16'h0000; step(20);
    strike_ready = 1'b0;
    sw = 16'h0020;
    wait_strike(5, lat, ok);
    chk("bp_seen", ok, 1);
    @(posedge clk); #1;
    clr_cnt();
    sw = 16'h0220;
    step(20);
    chk("bp_held_strike", strike, 16'h0020);
    chk("bp_held_valid", strike_valid, 1);
    chk("bp_drop", dcnt, 1);
    sw = 16'h0620;
    step(10);
    clr_cnt();
    strike_ready = 1'b1;
    step(12);
    chk("hold_accepted", strike_valid, 0);
    chk("hold_one_visible", vcnt, 1);
    chk("hold_drop", dcnt, 1);

    // Reset while a strike is pending.
    sw = 16'h0000; step(20);
    strike_ready = 1'b0;
    sw = 16'h0002;
    wait_strike(1, lat, ok);
    chk("rst_pending", ok, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_outputs", {player, strike, 4'(strike_idx), strike_valid, drop, multi}, 0);
    clr_cnt();
    strike_ready = 1'b1;
    step(40);
    chk("rst_no_strike", vcnt, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) sw = sw ^ (16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) sw = sw ^ 16'($urandom);
      strike_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 999) == 0);
      step(1);
    end
    reset = 1'b0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
